// File: rtl/window_fetch_ctrl_pkg.sv
// Shared constants, encodings and read-order helper for the 4x4 window fetch controller.
package window_fetch_ctrl_pkg;

    localparam int unsigned DefImgW    = 100;
    localparam int unsigned DefAddrW   = 14;
    localparam int unsigned WinDim     = 4;
    localparam int unsigned PixW       = 8;
    localparam int unsigned WinPix     = WinDim * WinDim;
    localparam int unsigned WinBits    = WinPix * PixW;
    localparam int unsigned LoadReads  = WinPix;
    localparam int unsigned ShiftReads = WinDim;

    typedef enum logic [1:0] {
        OpLoad       = 2'b00,
        OpShiftRight = 2'b01,
        OpShiftDown  = 2'b10,
        OpRsvd       = 2'b11
    } cmd_op_e;

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StDrain,
        StHold
    } state_e;

    typedef struct packed {
        logic [1:0] r;
        logic [1:0] c;
    } pix_pos_t;

    // Window position filled by read number idx; LOAD walks column-major.
    function automatic pix_pos_t read_pos(input cmd_op_e op, input logic [3:0] idx);
        pix_pos_t p;
        case (op)
            OpShiftRight: begin
                p.r = idx[1:0];
                p.c = 2'd3;
            end
            OpShiftDown: begin
                p.r = 2'd3;
                p.c = idx[1:0];
            end
            default: begin
                p.r = idx[1:0];
                p.c = idx[3:2];
            end
        endcase
        return p;
    endfunction

endpackage

// File: rtl/window_fetch_ctrl_win_shift_buf.sv
// 4x4 pixel window register with column shift, row shift and single-pixel capture.
module window_fetch_ctrl_win_shift_buf
    import window_fetch_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               shift_col,
    input  logic               shift_row,
    input  logic               cap_en,
    input  pix_pos_t           cap_pos,
    input  logic [PixW-1:0]    cap_data,
    output logic [WinBits-1:0] win
);

    logic [WinBits-1:0] win_q, win_d;

    always_comb begin
        win_d = win_q;
        if (shift_col) begin
            for (int r = 0; r < 4; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win_d[PixW*(WinDim*r+c) +: PixW] = win_q[PixW*(WinDim*r+c+1) +: PixW];
                end
            end
        end else if (shift_row) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 4; c++) begin
                    win_d[PixW*(WinDim*r+c) +: PixW] = win_q[PixW*(WinDim*(r+1)+c) +: PixW];
                end
            end
        end else if (cap_en) begin
            win_d[PixW*(WinDim*32'(cap_pos.r) + 32'(cap_pos.c)) +: PixW] = cap_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            win_q <= '0;
        end else begin
            win_q <= win_d;
        end
    end

    assign win = win_q;

endmodule

// File: rtl/window_fetch_ctrl.sv
// Fetches a 4x4 pixel window from ImgROM on LOAD, or one new column/row on SHIFT_RIGHT/SHIFT_DOWN.
module window_fetch_ctrl
    import window_fetch_ctrl_pkg::*;
#(
    parameter int unsigned IMG_W  = DefImgW,
    parameter int unsigned ADDR_W = DefAddrW
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [ADDR_W-1:0]  cmd_addr,
    output logic               rom_cen,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [7:0]         rom_q,
    output logic               win_valid,
    input  logic               win_ready,
    output logic [WinBits-1:0] win_data,
    output logic               busy
);

    state_e              state_q, state_d;
    cmd_op_e             op_q, op_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                loaded_q, loaded_d;
    logic                rom_cen_q, rom_cen_d;
    logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
    logic                cap_en_q;
    pix_pos_t            cap_pos_q;
    logic                shift_col, shift_row;
    logic [3:0]          last_idx;

    function automatic logic [ADDR_W-1:0] addr_of(input logic [ADDR_W-1:0] base,
                                                  input pix_pos_t pos);
        return base + ADDR_W'(32'(pos.r) * IMG_W + 32'(pos.c));
    endfunction

    assign last_idx = (op_q == OpLoad) ? 4'(LoadReads - 1) : 4'(ShiftReads - 1);

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        base_d     = base_q;
        cnt_d      = cnt_q;
        loaded_d   = loaded_q;
        rom_cen_d  = 1'b1;
        rom_addr_d = rom_addr_q;
        shift_col  = 1'b0;
        shift_row  = 1'b0;
        cmd_ready  = (state_q == StIdle) && !RST;
        unique case (state_q)
            StIdle: begin
                if (cmd_valid && cmd_ready) begin
                    // Shifts before the first completed LOAD fall back to a LOAD at cmd_addr.
                    op_d   = OpLoad;
                    base_d = cmd_addr;
                    if (loaded_q && cmd_op == OpShiftRight) begin
                        op_d      = OpShiftRight;
                        base_d    = base_q + ADDR_W'(1);
                        shift_col = 1'b1;
                    end else if (loaded_q && cmd_op == OpShiftDown) begin
                        op_d      = OpShiftDown;
                        base_d    = base_q + ADDR_W'(IMG_W);
                        shift_row = 1'b1;
                    end
                    cnt_d      = 4'd0;
                    rom_cen_d  = 1'b0;
                    rom_addr_d = addr_of(base_d, read_pos(op_d, 4'd0));
                    state_d    = StFetch;
                end
            end
            StFetch: begin
                if (cnt_q == last_idx) begin
                    state_d = StDrain;
                end else begin
                    cnt_d      = cnt_q + 4'd1;
                    rom_cen_d  = 1'b0;
                    rom_addr_d = addr_of(base_q, read_pos(op_q, cnt_d));
                end
            end
            StDrain: begin
                state_d = StHold;
                if (op_q == OpLoad) begin
                    loaded_d = 1'b1;
                end
            end
            StHold: begin
                if (win_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= StIdle;
            op_q       <= OpLoad;
            base_q     <= '0;
            cnt_q      <= '0;
            loaded_q   <= 1'b0;
            rom_cen_q  <= 1'b1;
            rom_addr_q <= '0;
            cap_en_q   <= 1'b0;
            cap_pos_q  <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            base_q     <= base_d;
            cnt_q      <= cnt_d;
            loaded_q   <= loaded_d;
            rom_cen_q  <= rom_cen_d;
            rom_addr_q <= rom_addr_d;
            // ROM samples the current address now; its data lands one cycle later.
            cap_en_q   <= ~rom_cen_q;
            cap_pos_q  <= read_pos(op_q, cnt_q);
        end
    end

    window_fetch_ctrl_win_shift_buf u_win_buf (
        .clk      (CLK),
        .rst      (RST),
        .shift_col(shift_col),
        .shift_row(shift_row),
        .cap_en   (cap_en_q),
        .cap_pos  (cap_pos_q),
        .cap_data (rom_q),
        .win      (win_data)
    );

    assign rom_cen   = rom_cen_q;
    assign rom_addr  = rom_addr_q;
    assign win_valid = (state_q == StHold);
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_window_fetch_ctrl.sv
// Directed bench for window_fetch_ctrl with an ImgROM model returning addr[7:0].
module tb_window_fetch_ctrl;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [1:0]   cmd_op = 2'b00;
    logic [13:0]  cmd_addr = '0;
    logic         rom_cen;
    logic [13:0]  rom_addr;
    logic [7:0]   rom_q = '0;
    logic         win_valid;
    logic         win_ready = 1'b0;
    logic [127:0] win_data;
    logic         busy;

    int checks = 0;
    int failures = 0;

    window_fetch_ctrl #(
        .IMG_W (100),
        .ADDR_W(14)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op   (cmd_op),
        .cmd_addr (cmd_addr),
        .rom_cen  (rom_cen),
        .rom_addr (rom_addr),
        .rom_q    (rom_q),
        .win_valid(win_valid),
        .win_ready(win_ready),
        .win_data (win_data),
        .busy     (busy)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (!rom_cen) rom_q <= rom_addr[7:0];
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pixel (r,c) of a window whose top-left address is base.
    function automatic logic [127:0] exp_win(input logic [13:0] base);
        logic [127:0] w;
        int tmp;
        w = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                tmp = int'(base) + 100 * r + c;
                w[8*(4*r+c) +: 8] = tmp[7:0];
            end
        end
        return w;
    endfunction

    // kind: 0 full load, 1 right shift, 2 down shift; base is the expected new B.
    task automatic run_op(input logic [1:0] op, input logic [13:0] addr, input int kind,
                          input logic [13:0] base, input int hold);
        int n;
        int lat;
        logic [13:0]  ea;
        logic [127:0] ew;
        n   = (kind == 0) ? 16 : 4;
        lat = n + 1;
        ew  = exp_win(base);
        chk("idle_cmd_ready", 128'(cmd_ready), 128'(1));
        cmd_op    = op;
        cmd_addr  = addr;
        cmd_valid = 1'b1;
        @(negedge CLK);
        cmd_valid = 1'b0;
        for (int j = 0; j <= lat; j++) begin
            if (j < n) begin
                case (kind)
                    0:       ea = base + 14'(100 * (j % 4) + j / 4);
                    1:       ea = base + 14'(3 + 100 * j);
                    default: ea = base + 14'(300 + j);
                endcase
                chk("rom_addr", 128'(rom_addr), 128'(ea));
                chk("rom_cen_fetch", 128'(rom_cen), 128'(0));
            end else begin
                chk("rom_cen_drain", 128'(rom_cen), 128'(1));
            end
            chk("win_valid_latency", 128'(win_valid), 128'(j == lat));
            chk("busy_active", 128'(busy), 128'(1));
            if (j < lat) @(negedge CLK);
        end
        chk("win_data", win_data, ew);
        for (int h = 0; h < hold; h++) begin
            cmd_valid = 1'b1;
            cmd_op    = 2'b00;
            cmd_addr  = 14'h123;
            @(negedge CLK);
            chk("hold_data", win_data, ew);
            chk("hold_valid", 128'(win_valid), 128'(1));
            chk("hold_cmd_ready", 128'(cmd_ready), 128'(0));
            chk("hold_rom_cen", 128'(rom_cen), 128'(1));
        end
        cmd_valid = 1'b0;
        win_ready = 1'b1;
        @(negedge CLK);
        win_ready = 1'b0;
        chk("release_valid", 128'(win_valid), 128'(0));
        chk("release_busy", 128'(busy), 128'(0));
        chk("release_cmd_ready", 128'(cmd_ready), 128'(1));
    endtask

    initial begin
        @(negedge CLK);
        @(negedge CLK);
        chk("rst_cmd_ready", 128'(cmd_ready), 128'(0));
        chk("rst_rom_cen", 128'(rom_cen), 128'(1));
        chk("rst_rom_addr", 128'(rom_addr), 128'(0));
        chk("rst_win_valid", 128'(win_valid), 128'(0));
        chk("rst_win_data", win_data, 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        RST = 1'b0;
        @(negedge CLK);

        // Shift before any load executes as LOAD at cmd_addr.
        run_op(2'b01, 14'd200, 0, 14'd200, 0);
        run_op(2'b00, 14'd0, 0, 14'd0, 0);
        run_op(2'b01, 14'd777, 1, 14'd1, 0);
        run_op(2'b10, 14'd777, 2, 14'd101, 10);

        // Abort a LOAD on its 7th fetch cycle.
        chk("abort_cmd_ready", 128'(cmd_ready), 128'(1));
        cmd_op    = 2'b00;
        cmd_addr  = 14'd20;
        cmd_valid = 1'b1;
        @(negedge CLK);
        cmd_valid = 1'b0;
        repeat (6) @(negedge CLK);
        chk("abort_pre_rom_cen", 128'(rom_cen), 128'(0));
        RST = 1'b1;
        @(negedge CLK);
        chk("abort_rom_cen", 128'(rom_cen), 128'(1));
        chk("abort_win_valid", 128'(win_valid), 128'(0));
        chk("abort_busy", 128'(busy), 128'(0));
        chk("abort_cmd_ready_rst", 128'(cmd_ready), 128'(0));
        chk("abort_rom_addr", 128'(rom_addr), 128'(0));
        RST = 1'b0;
        @(negedge CLK);

        run_op(2'b00, 14'd50, 0, 14'd50, 0);
        run_op(2'b10, 14'd9, 2, 14'd150, 0);
        // Reserved opcode loads; right shift then wraps the address space.
        run_op(2'b11, 14'd16380, 0, 14'd16380, 0);
        run_op(2'b01, 14'd999, 1, 14'd16381, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/window_fetch_ctrl.md
WINDOW_FETCH_CTRL -- requirements
Module: window_fetch_ctrl

Interface
REQ-001 Parameter: IMG_W, default 100, image row stride in pixels for ImgROM address arithmetic.
REQ-002 Parameter: ADDR_W, default 14, ImgROM address width.
REQ-003 Port: CLK  in  1  sole clock; all state updates on rising edge.
REQ-004 Port: RST  in  1  reset, synchronous, active-high.
REQ-005 Port: cmd_valid  in  1  command request.
REQ-006 Port: cmd_ready  out  1  command accept; transfer occurs on an edge where cmd_valid & cmd_ready.
REQ-007 Port: cmd_op  in  2  command: 00 LOAD, 01 SHIFT_RIGHT, 10 SHIFT_DOWN, 11 reserved (treated as LOAD).
REQ-008 Port: cmd_addr  in  ADDR_W  top-left pixel address; used by LOAD only.
REQ-009 Port: rom_cen  out  1  ImgROM chip enable, active-low, registered.
REQ-010 Port: rom_addr  out  ADDR_W  ImgROM address, registered.
REQ-011 Port: rom_q  in  8  ImgROM data, valid the cycle after the edge that sampled rom_addr with rom_cen=0.
REQ-012 Port: win_valid  out  1  4x4 window available.
REQ-013 Port: win_ready  in  1  consumer accepts window.
REQ-014 Port: win_data  out  128  pixel (r,c), r,c in 0..3, at bits 8*(4r+c)+7 .. 8*(4r+c); r is row (down), c is column (right).
REQ-015 Port: busy  out  1  high whenever state is not IDLE.

Function
REQ-016 FSM states SHALL be IDLE, FETCH, DRAIN, HOLD; cmd_ready SHALL be 1 only in IDLE with RST low.
REQ-017 On accept, the controller SHALL register base address B: LOAD sets B=cmd_addr; SHIFT_RIGHT sets B=B+1; SHIFT_DOWN sets B=B+IMG_W; all arithmetic modulo 2^ADDR_W, no saturation or bounds checking.
REQ-018 LOAD SHALL issue 16 consecutive reads, column-major: B+r*IMG_W+c for c=0..3, r=0..3 within each column.
REQ-019 SHIFT_RIGHT SHALL issue 4 reads B_new+3+r*IMG_W (r=0..3); on capture the window SHALL shift left one column and new pixels fill c=3.
REQ-020 SHIFT_DOWN SHALL issue 4 reads B_new+3*IMG_W+c (c=0..3); on capture the window SHALL shift up one row and new pixels fill r=3.
REQ-021 FETCH drives one address per cycle with rom_cen=0; DRAIN (one cycle, rom_cen=1) captures the final read; no idle cycles between reads.
REQ-022 Latency: win_valid SHALL rise 17 cycles after the accept edge for LOAD and 5 cycles after for SHIFT_*.
REQ-023 In HOLD, win_valid=1 and win_data SHALL remain stable until an edge with win_ready=1, after which state returns to IDLE and win_valid=0.
REQ-024 rom_cen SHALL be 1 in IDLE, DRAIN and HOLD.
REQ-025 A loaded flag SHALL set on first completed LOAD; SHIFT_* received while loaded=0 SHALL execute as LOAD at cmd_addr.
REQ-026 cmd_valid while not in IDLE SHALL be ignored (not accepted, not queued).

Reset
REQ-027 While RST=1: state IDLE, cmd_ready=0, rom_cen=1, rom_addr=0, win_valid=0, win_data=0, busy=0, B=0, loaded=0.
REQ-028 RST asserted mid-FETCH/DRAIN/HOLD SHALL abort the operation; outputs take reset values at the next edge and a subsequent LOAD behaves normally.

Structure
REQ-029 Shared package SHALL hold IMG_W, ADDR_W, cmd_op encodings, FSM state encoding and window geometry constants (4x4, 8-bit pixel).
REQ-030 One sub-module is natural: win_shift_buf (16x8 register array with column-shift, row-shift and indexed capture port).

Verification (ROM model: rom_q = addr[7:0])
REQ-031 LOAD cmd_addr=0 -> rom_addr 0,100,200,300,1,101,...,303; win_valid at cycle 17; win_data pixel (r,c)=(100r+c)&255.
REQ-032 Then SHIFT_RIGHT -> rom_addr 4,104,204,304; win_valid at cycle 5; pixel (r,c)=(100r+c+1)&255.
REQ-033 Then SHIFT_DOWN -> rom_addr 401,402,403,404; pixel (r,c)=(100(r+1)+c+1)&255.
REQ-034 win_ready held 0 for 10 cycles in HOLD -> win_data unchanged, cmd_ready=0, rom_cen=1 throughout.
REQ-035 RST pulsed on 7th FETCH cycle of a LOAD -> next edge rom_cen=1, win_valid=0, busy=0; LOAD cmd_addr=50 then completes correctly.
REQ-036 SHIFT_RIGHT with cmd_addr=200 directly after reset -> 16 reads starting at 200 (executes as LOAD).
